// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES CTR-mode counter register.
//   SliceSizeCtr  : width of one counter slice handed to the increment FSM
//   NumSlicesCtr  : slices per counter (counter width = product of the two)
//   SliceIdxWidth : width of a slice index
//   CtrCntDone    : write count after every slice has been written back
//   aes_ctr_reg_e : sequencer states, sparse so single/double flips are caught
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned SliceSizeCtr  = 16;
    localparam int unsigned NumSlicesCtr  = 8;
    localparam int unsigned SliceIdxWidth = 3;
    localparam int unsigned CtrWidth      = SliceSizeCtr * NumSlicesCtr;

    // One extra bit so the count can hold NumSlicesCtr itself.
    localparam logic [SliceIdxWidth:0] CtrCntDone = (SliceIdxWidth + 1)'(NumSlicesCtr);

    // Pairwise Hamming distance >= 3 between all encodings.
    typedef enum logic [5:0] {
        CtrIdle  = 6'b000111,
        CtrWait  = 6'b011000,
        CtrError = 6'b101101
    } aes_ctr_reg_e;

endpackage

// File: rtl/aes_ctr_reg.sv
// ----------------------------------------------------------------------------
// aes_ctr_reg
// 128-bit CTR-mode counter register and sequencer for the slice-wise
// increment FSM that sits beside this block. Software loads slices while idle;
// on a request the FSM reads one slice at a time through ctr_slice_o and
// writes the incremented slice back. This block never adds; it only stores,
// sequences and cross-checks the FSM's write-back order.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   iv_i, iv_we_i        software counter value and per-slice write enables
//   incr_req_i           level request from control, held until incr_ack_o
//   mr_err_i             multi-rail error from control -> ERROR
//   incr_ack_o           one-cycle completion pulse
//   ctr_o                current counter register
//   ctr_wrap_o           pulses with incr_ack_o when the result is all-zero
//   load_err_o           pulses when a software write is rejected (busy/error)
//   fsm_incr_o           start strobe to the increment FSM
//   fsm_ready_i          increment FSM idle
//   ctr_slice_idx_i      slice index driven by the FSM
//   ctr_slice_o          selected slice to the FSM
//   ctr_slice_i, ctr_we_i  incremented slice and its write enable from the FSM
//   incr_err_o, alert_o  error to the FSM and fatal alert (terminal until reset)
//
// Configuration
//   AES_CTR_REG_WRAP_ALERT_EN : when defined, a wrap at completion still acks
//   but moves to ERROR, so alert_o latches from the following cycle.
// ----------------------------------------------------------------------------
module aes_ctr_reg
    import aes_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [CtrWidth-1:0]      iv_i,
    input  logic [NumSlicesCtr-1:0]  iv_we_i,
    input  logic                     incr_req_i,
    input  logic                     mr_err_i,
    output logic                     incr_ack_o,
    output logic [CtrWidth-1:0]      ctr_o,
    output logic                     ctr_wrap_o,
    output logic                     load_err_o,
    output logic                     fsm_incr_o,
    input  logic                     fsm_ready_i,
    input  logic [SliceIdxWidth-1:0] ctr_slice_idx_i,
    output logic [SliceSizeCtr-1:0]  ctr_slice_o,
    input  logic [SliceSizeCtr-1:0]  ctr_slice_i,
    input  logic                     ctr_we_i,
    output logic                     incr_err_o,
    output logic                     alert_o
);

    aes_ctr_reg_e state_d, state_q;
    logic [SliceIdxWidth:0] cnt_d, cnt_q;
    logic [NumSlicesCtr-1:0][SliceSizeCtr-1:0] ctr_d, ctr_q;
    logic [NumSlicesCtr-1:0][SliceSizeCtr-1:0] iv_slices;
    logic idx_ok, wr_bad, ctr_zero;

    assign iv_slices   = iv_i;
    assign ctr_o       = ctr_q;
    assign ctr_slice_o = ctr_q[ctr_slice_idx_i];
    assign ctr_zero    = (ctr_q == '0);

    // The FSM must write slices strictly in order 0..NumSlicesCtr-1, so the
    // index it presents always equals the number of writes seen so far.
    assign idx_ok = ({1'b0, ctr_slice_idx_i} == cnt_q);
    assign wr_bad = ctr_we_i & ~idx_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctr_d      = ctr_q;
        incr_ack_o = 1'b0;
        ctr_wrap_o = 1'b0;
        load_err_o = 1'b0;
        fsm_incr_o = 1'b0;
        incr_err_o = 1'b0;
        alert_o    = 1'b0;

        case (state_q)
            CtrIdle: begin
                // Load first: an increment started this cycle reads the
                // freshly loaded slices from the next cycle on.
                for (int k = 0; k < NumSlicesCtr; k++) begin
                    if (iv_we_i[k]) ctr_d[k] = iv_slices[k];
                end
                fsm_incr_o = incr_req_i & fsm_ready_i;
                if (ctr_we_i) begin
                    state_d = CtrError;
                end else if (fsm_incr_o) begin
                    cnt_d   = '0;
                    state_d = CtrWait;
                end
            end

            CtrWait: begin
                load_err_o = |iv_we_i;
                if (ctr_we_i) begin
                    if (idx_ok) begin
                        ctr_d[ctr_slice_idx_i] = ctr_slice_i;
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = CtrError;
                    end
                end
                // An out-of-order write in the same cycle as ready must not
                // be masked by a completion.
                if (fsm_ready_i && !wr_bad) begin
                    if (cnt_q == CtrCntDone) begin
                        incr_ack_o = 1'b1;
                        ctr_wrap_o = ctr_zero;
`ifdef AES_CTR_REG_WRAP_ALERT_EN
                        state_d = ctr_zero ? CtrError : CtrIdle;
`else
                        state_d = CtrIdle;
`endif
                    end else begin
                        state_d = CtrError;
                    end
                end
            end

            CtrError: begin
                alert_o    = 1'b1;
                incr_err_o = 1'b1;
                load_err_o = |iv_we_i;
            end

            default: begin
                // Corrupted state encoding.
                alert_o    = 1'b1;
                incr_err_o = 1'b1;
                state_d    = CtrError;
            end
        endcase

        // Control-side fault overrides everything, including a same-cycle
        // slice write or completion.
        if (mr_err_i) begin
            state_d    = CtrError;
            ctr_d      = ctr_q;
            cnt_d      = cnt_q;
            incr_ack_o = 1'b0;
            ctr_wrap_o = 1'b0;
            fsm_incr_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CtrIdle;
            cnt_q   <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_aes_ctr_reg.sv
// ----------------------------------------------------------------------------
// tb_aes_ctr_reg
// Directed bench for aes_ctr_reg. A behavioural increment FSM drives the slice
// interface; completed increments are pushed to a queue and checked by an
// independent monitor on each incr_ack_o.
// ----------------------------------------------------------------------------
module tb_aes_ctr_reg;
    import aes_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [CtrWidth-1:0]      iv_i;
    logic [NumSlicesCtr-1:0]  iv_we_i;
    logic                     incr_req_i;
    logic                     mr_err_i;
    logic                     incr_ack_o;
    logic [CtrWidth-1:0]      ctr_o;
    logic                     ctr_wrap_o;
    logic                     load_err_o;
    logic                     fsm_incr_o;
    logic                     fsm_ready_i;
    logic [SliceIdxWidth-1:0] ctr_slice_idx_i;
    logic [SliceSizeCtr-1:0]  ctr_slice_o;
    logic [SliceSizeCtr-1:0]  ctr_slice_i;
    logic                     ctr_we_i;
    logic                     incr_err_o;
    logic                     alert_o;

    logic fsm_we, tb_we, fsm_idx_err;
    assign ctr_we_i = fsm_we | tb_we;

    aes_ctr_reg dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .iv_i(iv_i), .iv_we_i(iv_we_i),
        .incr_req_i(incr_req_i), .mr_err_i(mr_err_i), .incr_ack_o(incr_ack_o),
        .ctr_o(ctr_o), .ctr_wrap_o(ctr_wrap_o), .load_err_o(load_err_o),
        .fsm_incr_o(fsm_incr_o), .fsm_ready_i(fsm_ready_i),
        .ctr_slice_idx_i(ctr_slice_idx_i), .ctr_slice_o(ctr_slice_o),
        .ctr_slice_i(ctr_slice_i), .ctr_we_i(ctr_we_i),
        .incr_err_o(incr_err_o), .alert_o(alert_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [CtrWidth-1:0] ctr;
        logic                wrap;
        int                  start;
    } exp_t;
    exp_t exp_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [CtrWidth-1:0] act,
                       input logic [CtrWidth-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural increment FSM: slices 0..7 in consecutive cycles after the
    // strobe, ripple carry starting at 1, then ready again.
    task automatic run_fsm();
        logic carry;
        logic [SliceSizeCtr-1:0] s;
        carry = 1'b1;
        for (int k = 0; k < NumSlicesCtr; k++) begin
            @(posedge clk_i); #1;
            if (!rst_ni) begin
                fsm_we = 1'b0; fsm_ready_i = 1'b1;
                return;
            end
            fsm_ready_i     = 1'b0;
            ctr_slice_idx_i = (fsm_idx_err && k == 2) ? 3'd5 : 3'(k);
            #1;
            s           = ctr_slice_o;
            ctr_slice_i = s + {15'd0, carry};
            carry       = carry & (s == 16'hFFFF);
            fsm_we      = 1'b1;
        end
        @(posedge clk_i); #1;
        fsm_we = 1'b0; fsm_ready_i = 1'b1;
    endtask

    initial begin : fsm_model
        fsm_we = 1'b0; fsm_ready_i = 1'b1;
        ctr_slice_idx_i = '0; ctr_slice_i = '0;
        forever begin
            @(negedge clk_i);
            if (fsm_incr_o && rst_ni) run_fsm();
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (incr_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", incr_ack_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_ctr", ctr_o, e.ctr);
                    chk("ack_wrap", ctr_wrap_o, e.wrap);
                    chk("ack_latency", cyc - e.start, NumSlicesCtr + 1);
                end
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0; incr_req_i = 1'b0; iv_we_i = '0; tb_we = 1'b0;
        mr_err_i = 1'b0; fsm_idx_err = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic load(input logic [CtrWidth-1:0] v);
        @(posedge clk_i); #1;
        iv_i = v; iv_we_i = '1;
        @(posedge clk_i); #1;
        iv_we_i = '0;
        @(negedge clk_i);
        chk("load", ctr_o, v);
    endtask

    task automatic do_incr(input logic [CtrWidth-1:0] exp_ctr, input logic exp_wrap,
                           input logic ld, input logic [CtrWidth-1:0] ld_val,
                           input logic mid);
        bit got;
        got = 1'b0;
        @(posedge clk_i); #1;
        incr_req_i = 1'b1;
        if (ld) begin iv_i = ld_val; iv_we_i = '1; end
        exp_q.push_back('{ctr: exp_ctr, wrap: exp_wrap, start: cyc});
        @(negedge clk_i);
        chk("strobe", fsm_incr_o, 1);
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk_i); #1;
            iv_we_i = (mid && i == 4) ? '1 : '0;
            if (mid && i == 4) iv_i = {8{16'hA5A5}};
            @(negedge clk_i);
            if (mid && i == 4) chk("load_err_busy", load_err_o, 1);
            if (mid && i == 5) chk("load_err_clear", load_err_o, 0);
            if (incr_ack_o) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        @(posedge clk_i); #1;
        incr_req_i = 1'b0; iv_we_i = '0;
    endtask

    // Hold a request for n cycles and count acks (error-state checks).
    task automatic req_no_ack(input int n);
        int acks;
        acks = 0;
        @(posedge clk_i); #1;
        incr_req_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            acks += int'(incr_ack_o);
        end
        chk("no_ack_in_error", acks, 0);
        incr_req_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        iv_i = '0; iv_we_i = '0; incr_req_i = 1'b0; mr_err_i = 1'b0;
        tb_we = 1'b0; fsm_idx_err = 1'b0; rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        do_reset();

        // Reset values.
        chk("rst_ctr", ctr_o, 0);
        chk("rst_alert", alert_o, 0);
        chk("rst_incr_err", incr_err_o, 0);
        chk("rst_fsm_incr", fsm_incr_o, 0);
        chk("rst_ack", incr_ack_o, 0);
        chk("rst_wrap", ctr_wrap_o, 0);
        chk("rst_load_err", load_err_o, 0);

        // Basic increments, carry across slice boundaries.
        load(128'h0);
        do_incr(128'h1, 1'b0, 1'b0, '0, 1'b0);
        load(128'h0000_FFFF);
        do_incr(128'h1_0000, 1'b0, 1'b0, '0, 1'b0);
        // Load in the same cycle as the request.
        do_incr(128'h2_0000, 1'b0, 1'b1, 128'h1_FFFF, 1'b0);

        // All-ones wraps to zero.
        load({CtrWidth{1'b1}});
        do_incr(128'h0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
`ifdef AES_CTR_REG_WRAP_ALERT_EN
        chk("wrap_alert", alert_o, 1);
        chk("wrap_incr_err", incr_err_o, 1);
        do_reset();
`else
        chk("wrap_no_alert", alert_o, 0);
        do_incr(128'h1, 1'b0, 1'b0, '0, 1'b0);
`endif

        // Software write during an increment is rejected.
        load(128'h00FF_FFFF_FFFF);
        do_incr(128'h0100_0000_0000, 1'b0, 1'b0, '0, 1'b1);

        // Stray slice write while idle.
        @(posedge clk_i); #1; tb_we = 1'b1;
        @(posedge clk_i); #1; tb_we = 1'b0;
        @(negedge clk_i);
        chk("idle_we_alert", alert_o, 1);
        chk("idle_we_incr_err", incr_err_o, 1);
        req_no_ack(15);
        chk("idle_we_alert_held", alert_o, 1);
        do_reset();

        // Out-of-order slice index during an increment.
        load(128'h0);
        fsm_idx_err = 1'b1;
        req_no_ack(20);
        chk("idx_alert", alert_o, 1);
        chk("idx_incr_err", incr_err_o, 1);
        chk("idx_ctr_held", ctr_o, 128'h1);
        do_reset();

        // Multi-rail error from control.
        @(posedge clk_i); #1; mr_err_i = 1'b1;
        @(posedge clk_i); #1; mr_err_i = 1'b0;
        @(negedge clk_i);
        chk("mr_err_alert", alert_o, 1);
        do_reset();

        // Reset in WAIT cycle 4, then a clean increment.
        load(128'h5);
        @(posedge clk_i); #1;
        incr_req_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0; incr_req_i = 1'b0;
        #1;
        chk("midrst_ctr", ctr_o, 0);
        chk("midrst_alert", alert_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        do_incr(128'h1, 1'b0, 1'b0, '0, 1'b0);

        repeat (5) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
